// File: rtl/mem_arbiter.sv
// mem_arbiter
// Shares the single data-memory handshake between the instruction-side cache
// (port 0) and the data-side write-back cache (port 1). It serves one request
// at a time and holds the memory strobe, address and data stable until memory
// answers. It then returns a one-cycle response to the owning port. A sticky
// error flag records any memory access that never completed.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no transaction; arbitrate between requesting ports
// BUSY    | strobe to memory held from latched registers, waiting mem_valid
// RESP    | one-cycle response pulse to the owner, memory strobes low

module mem_arbiter #(
   parameter int TIMEOUT    = 16,
   parameter int FIXED_PRIO = 0
) (
   input  logic        clk,
   input  logic        rst,

   input  logic        req0_read,
   input  logic        req0_write,
   input  logic [31:0] req0_addr,
   input  logic [31:0] req0_wdata,
   output logic        resp0_valid,
   output logic [31:0] resp0_rdata,

   input  logic        req1_read,
   input  logic        req1_write,
   input  logic [31:0] req1_addr,
   input  logic [31:0] req1_wdata,
   output logic        resp1_valid,
   output logic [31:0] resp1_rdata,

   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   input  logic        mem_valid,

   output logic        busy,
   output logic        timeout_err
);

   // Last counter value of a BUSY phase; TIMEOUT is limited to 2..255.
   localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUSY = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t      r_state;
   state_t      w_state_nxt;

   logic        r_owner;
   logic        r_op_write;
   logic        r_last_grant;
   logic        r_timeout_err;
   logic [31:0] r_addr;
   logic [31:0] r_wdata;
   logic [31:0] r_rdata;
   logic [7:0]  r_cnt;

   logic        w_req0;
   logic        w_req1;
   logic        w_any_req;
   logic        w_grant_port;
   logic        w_grant_write;
   logic [31:0] w_grant_addr;
   logic [31:0] w_grant_wdata;
   logic        w_in_idle;
   logic        w_in_busy;
   logic        w_in_resp;
   logic        w_tmo_hit;
   logic        w_grant;
   logic        w_mem_done;
   logic        w_tmo_fire;

   assign w_req0    = req0_read | req0_write;
   assign w_req1    = req1_read | req1_write;
   assign w_any_req = w_req0 | w_req1;

   assign w_in_idle = (r_state == ST_IDLE);
   assign w_in_busy = (r_state == ST_BUSY);
   assign w_in_resp = (r_state == ST_RESP);

   assign w_tmo_hit  = (r_cnt == CNT_LAST);
   assign w_grant    = w_in_idle & w_any_req;
   assign w_mem_done = w_in_busy & mem_valid;
   assign w_tmo_fire = w_in_busy & ~mem_valid & w_tmo_hit;

   // Arbitration: a lone requester wins; a tie goes to port 1 under fixed
   // priority, otherwise to the port that was not granted last.
   always_comb begin
      w_grant_port = 1'b0;
      if (w_req0 && w_req1) begin
         if (FIXED_PRIO != 0) begin
            w_grant_port = 1'b1;
         end else begin
            w_grant_port = ~r_last_grant;
         end
      end else begin
         w_grant_port = w_req1;
      end
   end

   // Operation of the winner; a simultaneous read is dropped in favour of the write.
   always_comb begin
      w_grant_write = req0_write;
      w_grant_addr  = req0_addr;
      w_grant_wdata = req0_wdata;
      if (w_grant_port) begin
         w_grant_write = req1_write;
         w_grant_addr  = req1_addr;
         w_grant_wdata = req1_wdata;
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state decode; mem_valid only matters while BUSY.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE: begin
            if (w_any_req) begin
               w_state_nxt = ST_BUSY;
            end
         end
         ST_BUSY: begin
            if (mem_valid || w_tmo_hit) begin
               w_state_nxt = ST_RESP;
            end
         end
         ST_RESP: begin
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // Transaction registers captured on grant and held through BUSY and RESP.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_owner    <= 1'b0;
         r_op_write <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
      end else if (w_grant) begin
         r_owner    <= w_grant_port;
         r_op_write <= w_grant_write;
         r_addr     <= w_grant_addr;
         r_wdata    <= w_grant_wdata;
      end
   end

   // Last-grant history for round-robin; reset to port 1 so port 0 wins the first tie.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_last_grant <= 1'b1;
      end else if (w_grant) begin
         r_last_grant <= w_grant_port;
      end
   end

   // BUSY cycle counter, cleared on grant and advanced while memory is silent.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt <= '0;
      end else if (w_grant) begin
         r_cnt <= '0;
      end else if (w_in_busy && !mem_valid && !w_tmo_hit) begin
         r_cnt <= r_cnt + 8'd1;
      end
   end

   // Response data: memory read data, or zero for writes and timeouts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rdata <= '0;
      end else if (w_mem_done) begin
         r_rdata <= r_op_write ? 32'd0 : mem_rdata;
      end else if (w_tmo_fire) begin
         r_rdata <= '0;
      end
   end

   // Sticky timeout flag; only reset clears it.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_timeout_err <= 1'b0;
      end else if (w_tmo_fire) begin
         r_timeout_err <= 1'b1;
      end
   end

   // Outputs are decoded from registered state only.
   assign busy        = w_in_busy | w_in_resp;
   assign mem_read    = w_in_busy & ~r_op_write;
   assign mem_write   = w_in_busy & r_op_write;
   assign mem_addr    = r_addr;
   assign mem_wdata   = r_wdata;
   assign resp0_valid = w_in_resp & ~r_owner;
   assign resp1_valid = w_in_resp & r_owner;
   assign resp0_rdata = resp0_valid ? r_rdata : 32'd0;
   assign resp1_rdata = resp1_valid ? r_rdata : 32'd0;
   assign timeout_err = r_timeout_err;

endmodule
